// File: rtl/reg32_cmd_ctrl.sv
// reg32_cmd_ctrl: command front-end for the 16x32 register file.
// Buffers write/read commands in an in-order FIFO, sequences them onto the
// register-file pins honouring RD_LAT, and returns read data on a
// valid/ready response channel.
// Optional macro REG32_CTRL_READBACK_EN: read back every write and flag the
// first mismatching line on err_flag/err_line.
module reg32_cmd_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_line,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_read_en,
  output logic [ADDR_W-1:0] rf_read_line,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_line
);

  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam int unsigned   CW        = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [1:0]    WAIT_LAST = 2'(RD_LAT - 1);

`ifdef REG32_CTRL_READBACK_EN
  typedef enum logic [2:0] {
    IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP, VERIFY_ISSUE, VERIFY_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP
  } state_t;
`endif

  state_t state, state_next;

  logic              fifo_wr   [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;
  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        wait_cnt;
  logic              wait_done;

  assign cmd_ready = !reset && (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign head_wr   = fifo_wr[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign wait_done = (wait_cnt == WAIT_LAST);

  // FIFO storage: written on every accepted command, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]   <= cmd_wr;
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_data[wr_ptr] <= cmd_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and FIFO pop
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = head_wr ? WRITE : RD_ISSUE;
        end
      end
`ifdef REG32_CTRL_READBACK_EN
      WRITE:        state_next = VERIFY_ISSUE;
      VERIFY_ISSUE: state_next = VERIFY_WAIT;
      VERIFY_WAIT:  if (wait_done) state_next = IDLE;
`else
      WRITE:        state_next = IDLE;
`endif
      RD_ISSUE:     state_next = RD_WAIT;
      RD_WAIT:      if (wait_done) state_next = RESP;
      RESP:         if (rsp_ready) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // Read-latency counter, runs only while waiting on rf_data_out
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
`ifdef REG32_CTRL_READBACK_EN
    end else if ((state == RD_WAIT || state == VERIFY_WAIT) && !wait_done) begin
`else
    end else if (state == RD_WAIT && !wait_done) begin
`endif
      wait_cnt <= wait_cnt + 2'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Registered register-file and response outputs.
  // Enables are decoded from state_next so they are high exactly while the
  // FSM sits in the matching issue state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_en   <= 1'b0;
      rf_write_line <= '0;
      rf_data_in    <= '0;
      rf_read_en    <= 1'b0;
      rf_read_line  <= '0;
      rsp_valid     <= 1'b0;
      rsp_addr      <= '0;
      rsp_rdata     <= '0;
    end else begin
      rf_write_en <= (state_next == WRITE);
`ifdef REG32_CTRL_READBACK_EN
      rf_read_en  <= (state_next == RD_ISSUE) || (state_next == VERIFY_ISSUE);
`else
      rf_read_en  <= (state_next == RD_ISSUE);
`endif
      if (pop && head_wr) begin
        rf_write_line <= head_addr;
        rf_data_in    <= head_data;
      end
      if (pop && !head_wr) rf_read_line <= head_addr;
`ifdef REG32_CTRL_READBACK_EN
      if (state == WRITE) rf_read_line <= rf_write_line;
`endif
      if (state == RD_WAIT && wait_done) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= rf_read_line;
        rsp_rdata <= rf_data_out;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef REG32_CTRL_READBACK_EN
  // Sticky readback error; only the first mismatching line is recorded
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_line <= '0;
    end else if (state == VERIFY_WAIT && wait_done && !err_flag &&
                 (rf_data_out != rf_data_in)) begin
      err_flag <= 1'b1;
      err_line <= rf_write_line;
    end
  end
`else
  assign err_flag = 1'b0;
  assign err_line = '0;
`endif

endmodule

// File: tb/tb_reg32_cmd_ctrl.sv
// Self-checking bench for reg32_cmd_ctrl: directed vector table, corner-case
// sequences and randomized traffic against an in-order memory model.
`timescale 1ns/1ps
module tb_reg32_cmd_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic        rf_write_en, rf_read_en;
  logic [3:0]  rf_write_line, rf_read_line;
  logic [31:0] rf_data_in, rf_data_out;
  logic        err_flag;
  logic [3:0]  err_line;

  always #5 clk = ~clk;

  reg32_cmd_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .rf_write_en(rf_write_en), .rf_write_line(rf_write_line),
    .rf_data_in(rf_data_in), .rf_read_en(rf_read_en),
    .rf_read_line(rf_read_line), .rf_data_out(rf_data_out),
    .err_flag(err_flag), .err_line(err_line)
  );

  // Register-file model: registered read, poisoned output when no read issued
  logic [31:0] rf_mem  [16]     = '{default: '0};
  logic [31:0] rd_pipe [RD_LAT] = '{default: '0};
  logic        inject_fault     = 1'b0;

  always @(posedge clk) begin
    if (rf_write_en) begin
      if (inject_fault && (rf_write_line == 4'd7 || rf_write_line == 4'd9))
        rf_mem[rf_write_line] <= rf_data_in & ~32'h1;
      else
        rf_mem[rf_write_line] <= rf_data_in;
    end
    rd_pipe[0] <= rf_read_en ? rf_mem[rf_read_line] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rf_data_out = rd_pipe[RD_LAT-1];

  // Reference model: memory image in command order plus expected traffic
  typedef struct packed { logic [3:0] addr; logic [31:0] data; } pair_t;
  pair_t       exp_rsp_q[$];
  pair_t       exp_wr_q[$];
  logic [31:0] ref_mem [16] = '{default: '0};

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;

  // Snapshot of DUT outputs taken by tick()
  logic        s_accept, s_cmd_ready, s_rsp_valid, s_wen, s_ren, s_err;
  logic [3:0]  s_raddr, s_wline, s_rline, s_eline;
  logic [31:0] s_rdata, s_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample just before the rising edge, update the model, advance one cycle
  task automatic tick();
    pair_t p;
    #1;
    s_cmd_ready = cmd_ready;  s_accept = cmd_valid && cmd_ready;
    s_rsp_valid = rsp_valid;  s_raddr  = rsp_addr;   s_rdata = rsp_rdata;
    s_wen       = rf_write_en; s_wline = rf_write_line; s_din = rf_data_in;
    s_ren       = rf_read_en;  s_rline = rf_read_line;
    s_err       = err_flag;    s_eline = err_line;
    if (s_accept) begin
      p.addr = cmd_addr;
      if (cmd_wr) begin
        ref_mem[cmd_addr] = cmd_wdata;
        p.data = cmd_wdata;
        exp_wr_q.push_back(p);
      end else begin
        p.data = ref_mem[cmd_addr];
        exp_rsp_q.push_back(p);
      end
    end
    if (s_wen) begin
      if (exp_wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got line %0h data %0h required none", s_wline, s_din);
      end else begin
        p = exp_wr_q.pop_front();
        check("wr_line", 32'(s_wline), 32'(p.addr));
        check("wr_data", s_din, p.data);
      end
    end
    if (s_rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_rsp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got addr %0h data %0h required none", s_raddr, s_rdata);
      end else begin
        p = exp_rsp_q.pop_front();
        check("rsp_addr", 32'(s_raddr), 32'(p.addr));
        check("rsp_data", s_rdata, p.data);
      end
    end
    if (reset) begin
      exp_rsp_q.delete();
      exp_wr_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid"}, 32'(s_rsp_valid), 0);
    check({tag, "_rsp_addr"},  32'(s_raddr), 0);
    check({tag, "_rsp_rdata"}, s_rdata, 0);
    check({tag, "_wen"},       32'(s_wen), 0);
    check({tag, "_wline"},     32'(s_wline), 0);
    check({tag, "_din"},       s_din, 0);
    check({tag, "_ren"},       32'(s_ren), 0);
    check({tag, "_rline"},     32'(s_rline), 0);
    check({tag, "_err"},       32'(s_err), 0);
    check({tag, "_eline"},     32'(s_eline), 0);
  endtask

  task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_line;
    logic [31:0] exp_data;
    int          exp_cycle;
  } vec_t;

  vec_t vecs [7];

  initial begin
    pair_t       list [5];
    logic [31:0] held;
    int          en_cnt, en_first, rsp_first, idx, acc_k, lat, busy;
    logic [3:0]  got_line;
    logic [31:0] got_data;

    // write enables appear at cycle 2; read responses at cycle 3+RD_LAT
    vecs[0] = '{1'b1, 4'd3,  32'h0000F0FF, 4'd3,  32'h0000F0FF, 2};
    vecs[1] = '{1'b1, 4'd15, 32'hFFFFFFFF, 4'd15, 32'hFFFFFFFF, 2};
    vecs[2] = '{1'b0, 4'd3,  32'h0,        4'd3,  32'h0000F0FF, 4};
    vecs[3] = '{1'b0, 4'd15, 32'h0,        4'd15, 32'hFFFFFFFF, 4};
    vecs[4] = '{1'b1, 4'd0,  32'hA5A55A5A, 4'd0,  32'hA5A55A5A, 2};
    vecs[5] = '{1'b0, 4'd0,  32'h0,        4'd0,  32'hA5A55A5A, 4};
    vecs[6] = '{1'b0, 4'd9,  32'h0,        4'd9,  32'h0,        4};

    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    check("reset_cmd_ready", 32'(s_cmd_ready), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_cmd_ready", 32'(s_cmd_ready), 1);
    check_quiet("post_reset");

    // Directed vectors from idle with an empty FIFO
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      check($sformatf("vec%0d_accept", v), 32'(s_accept), 1);
      en_cnt = 0; en_first = 0; rsp_first = 0;
      got_line = '0; got_data = '0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (vecs[v].wr ? s_wen : s_ren) begin
          en_cnt++;
          if (en_first == 0) begin
            en_first = k;
            if (vecs[v].wr) begin got_line = s_wline; got_data = s_din; end
          end
        end
        if (s_rsp_valid && rsp_first == 0) begin
          rsp_first = k;
          if (!vecs[v].wr) begin got_line = s_raddr; got_data = s_rdata; end
        end
      end
      check($sformatf("vec%0d_en_count", v), 32'(en_cnt), 1);
      check($sformatf("vec%0d_en_cycle", v), 32'(en_first), 2);
      check($sformatf("vec%0d_line", v), 32'(got_line), 32'(vecs[v].exp_line));
      check($sformatf("vec%0d_data", v), got_data, vecs[v].exp_data);
      check($sformatf("vec%0d_rsp_cycle", v), 32'(rsp_first),
            vecs[v].wr ? 32'd0 : 32'(vecs[v].exp_cycle));
      if (v == 0) check("vec0_err_flag", 32'(s_err), 0);
    end

    // Write then read every line; read latency from idle is 3+RD_LAT
    idx = n_rsp;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 4'(i), 32'(i));
      repeat (6) tick();
      send(1'b0, 4'(i), 32'h0);
      lat = 0;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
        tick();
        if (s_rsp_valid) begin lat = k; got_line = s_raddr; got_data = s_rdata; end
      end
      check($sformatf("sweep%0d_latency", i), 32'(lat), 32'(3 + RD_LAT));
      check($sformatf("sweep%0d_addr", i), 32'(got_line), 32'(i));
      check($sformatf("sweep%0d_data", i), got_data, 32'(i));
      repeat (2) tick();
    end
    check("sweep_rsp_count", 32'(n_rsp - idx), 16);

    // Backpressure: stall in RESP, fill the FIFO, fifth command held off
    rsp_ready = 1'b0;
    send(1'b0, 4'd2, 32'h0);
    busy = 0;
    while (!s_rsp_valid && busy < 10) begin tick(); busy++; end
    check("stall_rsp_seen", 32'(s_rsp_valid), 1);
    held = s_rdata;
    check("stall_held_data", held, 32'd2);
    list[0] = '{4'd4, 32'h44}; list[1] = '{4'd4, 32'h0}; list[2] = '{4'd5, 32'h0};
    list[3] = '{4'd6, 32'h66}; list[4] = '{4'd6, 32'h0};
    idx = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cmd_wr    = (idx == 0 || idx == 3);
      cmd_addr  = list[idx].addr;
      cmd_wdata = list[idx].data;
      tick();
      if (s_accept) idx++;
      check($sformatf("stall%0d_valid", c), 32'(s_rsp_valid), 1);
      check($sformatf("stall%0d_rdata", c), s_rdata, held);
    end
    check("stall_accepted", 32'(idx), 4);
    check("stall_cmd_ready", 32'(s_cmd_ready), 0);
    rsp_ready = 1'b1;
    acc_k = 0;
    for (int k = 1; k <= 20 && acc_k == 0; k++) begin
      tick();
      if (s_accept) acc_k = k;
    end
    cmd_valid = 1'b0;
    check("fifth_accept_cycle", 32'(acc_k), 3);
    busy = 0;
    while ((exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) && busy < 60) begin
      tick(); busy++;
    end
    check("drain_rsp_q", 32'(exp_rsp_q.size()), 0);
    check("drain_wr_q", 32'(exp_wr_q.size()), 0);
    repeat (4) tick();

    // Reset while a read sits in RD_WAIT with two more reads queued
    send(1'b0, 4'd1, 32'h0);
    send(1'b0, 4'd2, 32'h0);
    send(1'b0, 4'd3, 32'h0);
    reset = 1'b1;
    tick();
    check("midrst_cmd_ready", 32'(s_cmd_ready), 0);
    tick();
    reset = 1'b0;
    tick();
    check("midrst_cmd_ready_after", 32'(s_cmd_ready), 1);
    check_quiet("midrst");
    busy = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_rsp_valid || s_wen || s_ren) busy++;
    end
    check("midrst_no_activity", 32'(busy), 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_wr    = $urandom_range(0, 1) == 1;
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    busy = 0;
    while ((exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) && busy < 100) begin
      tick(); busy++;
    end
    check("rand_rsp_q_empty", 32'(exp_rsp_q.size()), 0);
    check("rand_wr_q_empty", 32'(exp_wr_q.size()), 0);
    repeat (6) tick();
    check("clean_err_flag", 32'(s_err), 0);
    check("clean_err_line", 32'(s_eline), 0);

`ifdef REG32_CTRL_READBACK_EN
    inject_fault = 1'b1;
    send(1'b1, 4'd7, 32'h1);
    repeat (8) tick();
    check("rb_err_flag", 32'(s_err), 1);
    check("rb_err_line", 32'(s_eline), 7);
    send(1'b1, 4'd9, 32'h1);
    repeat (8) tick();
    check("rb_err_flag_sticky", 32'(s_err), 1);
    check("rb_err_line_first", 32'(s_eline), 7);
    inject_fault = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
